// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/decode/register-file handshake bundle for decode_stage
interface decode_stage_if;
    logic       inValid;
    logic       inReady;
    logic [8:0] instruction;
    logic       flush;
    logic       outValid;
    logic       outReady;
    logic [2:0] readRegister1;
    logic [2:0] readRegister2;
    logic [2:0] writeRegister;
    logic       immediate;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [2:0] aluOp;
    logic [7:0] ltValue;
    logic [7:0] bubbleCount;

    // master: fetch plus downstream consumer; slave: the decode stage itself
    modport master (
        output inValid, instruction, flush, outReady,
        input  inReady, outValid, readRegister1, readRegister2, writeRegister,
        input  immediate, regWrite, memRead, memWrite, branch, aluOp, ltValue, bubbleCount
    );

    modport slave (
        input  inValid, instruction, flush, outReady,
        output inReady, outValid, readRegister1, readRegister2, writeRegister,
        output immediate, regWrite, memRead, memWrite, branch, aluOp, ltValue, bubbleCount
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry decode stage; load-use interlock under DECODE_HAZARD_EN
module decode_stage #(
    parameter logic [63:0] LT_INIT = 64'h8040201008040201
) (
    input logic           clock,
    input logic           resetN,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [2:0] readRegister1;
        logic [2:0] readRegister2;
        logic [2:0] writeRegister;
        logic       immediate;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic [2:0] aluOp;
        logic [7:0] ltValue;
    } decodeT;

    logic [2:0] op;
    logic [2:0] fieldA;
    logic [2:0] fieldB;
    logic [7:0] lutEntry;
    decodeT     incoming;
    decodeT     held;
    logic       outValidQ;
    logic       hazard;
    logic       accept;

    assign op       = bus.instruction[8:6];
    assign fieldA   = bus.instruction[5:3];
    assign fieldB   = bus.instruction[2:0];
    assign lutEntry = LT_INIT[{fieldB, 3'b000} +: 8];

    always_comb begin
        incoming = '0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
                incoming.readRegister1 = fieldA;
                incoming.readRegister2 = fieldB;
                incoming.writeRegister = fieldA;
                incoming.regWrite      = 1'b1;
                incoming.aluOp         = op;
            end
            3'b100: begin
                incoming.readRegister1 = fieldA;
                incoming.writeRegister = fieldA;
                incoming.regWrite      = 1'b1;
                incoming.immediate     = 1'b1;
                incoming.ltValue       = lutEntry;
                incoming.aluOp         = 3'b100;
            end
            3'b101: begin
                incoming.readRegister1 = fieldB;
                incoming.writeRegister = fieldA;
                incoming.regWrite      = 1'b1;
                incoming.memRead       = 1'b1;
            end
            3'b110: begin
                incoming.readRegister1 = fieldA;
                incoming.readRegister2 = fieldB;
                incoming.memWrite      = 1'b1;
            end
            default: begin
                incoming.readRegister1 = fieldA;
                incoming.immediate     = 1'b1;
                incoming.ltValue       = lutEntry;
                incoming.branch        = 1'b1;
            end
        endcase
    end

`ifdef DECODE_HAZARD_EN
    logic       usesRr2;
    logic       readsHeld;
    logic [7:0] bubbleCountQ;

    assign usesRr2   = !op[2] || (op == 3'b110);
    assign readsHeld = (incoming.readRegister1 == held.writeRegister) ||
                       (usesRr2 && (incoming.readRegister2 == held.writeRegister));
    assign hazard    = outValidQ && held.memRead && bus.inValid && readsHeld;

    // a flushed hazard cycle is not a bubble, it is a discard
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bubbleCountQ <= 8'd0;
        end else if (hazard && bus.outReady && !bus.flush && (bubbleCountQ != 8'hFF)) begin
            bubbleCountQ <= bubbleCountQ + 8'd1;
        end
    end

    assign bus.bubbleCount = bubbleCountQ;
`else
    assign hazard          = 1'b0;
    assign bus.bubbleCount = 8'd0;
`endif

    assign bus.inReady = !bus.flush && !hazard && (!outValidQ || bus.outReady);
    assign accept      = bus.inValid && bus.inReady;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            held      <= '0;
            outValidQ <= 1'b0;
        end else if (bus.flush) begin
            outValidQ <= 1'b0;
        end else if (accept) begin
            held      <= incoming;
            outValidQ <= 1'b1;
        end else if (bus.outReady) begin
            outValidQ <= 1'b0;
        end
    end

    assign bus.outValid      = outValidQ;
    assign bus.readRegister1 = held.readRegister1;
    assign bus.readRegister2 = held.readRegister2;
    assign bus.writeRegister = held.writeRegister;
    assign bus.immediate     = held.immediate;
    assign bus.regWrite      = held.regWrite;
    assign bus.memRead       = held.memRead;
    assign bus.memWrite      = held.memWrite;
    assign bus.branch        = held.branch;
    assign bus.aluOp         = held.aluOp;
    assign bus.ltValue       = held.ltValue;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    decode_stage_if bus();
    decode_stage dut (.clock(clock), .resetN(resetN), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [24:0] dutFields;
    assign dutFields = {bus.readRegister1, bus.readRegister2, bus.writeRegister,
                        bus.immediate, bus.regWrite, bus.memRead, bus.memWrite, bus.branch,
                        bus.aluOp, bus.ltValue};

    // expected fields from the opcode table: {rr1, rr2, wr, imm/rw/mr/mw/br, aluOp, ltValue}
    function automatic logic [24:0] refFields(input logic [8:0] ins);
        logic [2:0] o;
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] lut;
        o   = ins[8:6];
        a   = ins[5:3];
        b   = ins[2:0];
        lut = 8'(1 << b);
        case (o)
            3'd0, 3'd1, 3'd2, 3'd3: return {a, b, a, 5'b01000, o, 8'h00};
            3'd4:                   return {a, 3'd0, a, 5'b11000, 3'b100, lut};
            3'd5:                   return {b, 3'd0, a, 5'b01100, 3'd0, 8'h00};
            3'd6:                   return {a, b, 3'd0, 5'b00010, 3'd0, 8'h00};
            default:                return {a, 3'd0, 3'd0, 5'b10001, 3'd0, lut};
        endcase
    endfunction

    logic       mValid   = 1'b0;
    logic [8:0] mInstr   = '0;
    int         mBubbles = 0;

    function automatic logic modelHazard(input logic v, input logic [8:0] heldIns,
                                         input logic inV, input logic [8:0] ins);
`ifdef DECODE_HAZARD_EN
        logic [2:0] r1;
        logic       twoRegs;
        if (!v || heldIns[8:6] != 3'd5 || !inV) return 1'b0;
        r1      = (ins[8:6] == 3'd5) ? ins[2:0] : ins[5:3];
        twoRegs = (ins[8:6] <= 3'd3) || (ins[8:6] == 3'd6);
        return (r1 == heldIns[5:3]) || (twoRegs && ins[2:0] == heldIns[5:3]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic modelReady(input logic v, input logic hz, input logic fl, input logic oRdy);
        return !fl && !hz && (!v || oRdy);
    endfunction

    logic mHz;
    logic mRdy;
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mValid   = 1'b0;
            mInstr   = '0;
            mBubbles = 0;
        end else begin
            mHz  = modelHazard(mValid, mInstr, bus.inValid, bus.instruction);
            mRdy = modelReady(mValid, mHz, bus.flush, bus.outReady);
            if (mHz && bus.outReady && !bus.flush && mBubbles < 255) mBubbles++;
            if (bus.flush) mValid = 1'b0;
            else if (bus.inValid && mRdy) begin
                mValid = 1'b1;
                mInstr = bus.instruction;
            end else if (bus.outReady) mValid = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!resetN) begin
            check("reset outValid", bus.outValid, 1'b0);
            check("reset fields", dutFields, 25'd0);
            check("reset bubbleCount", bus.bubbleCount, 8'd0);
        end else begin
            check("outValid", bus.outValid, mValid);
            check("inReady", bus.inReady,
                  modelReady(mValid, modelHazard(mValid, mInstr, bus.inValid, bus.instruction),
                             bus.flush, bus.outReady));
            check("bubbleCount", bus.bubbleCount, 64'(mBubbles));
            if (mValid) check("fields", dutFields, refFields(mInstr));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int b0;
    initial begin
        resetN          = 1'b0;
        bus.inValid     = 1'b0;
        bus.instruction = '0;
        bus.flush       = 1'b0;
        bus.outReady    = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        check("inReady after reset", bus.inReady, 1'b1);

        // LDI r3, LUT[2]
        bus.inValid = 1'b1; bus.instruction = 9'b100_011_010; bus.outReady = 1'b1;
        step();
        bus.inValid = 1'b0;
        check("ldi outValid", bus.outValid, 1'b1);
        check("ldi rr1", bus.readRegister1, 3'd3);
        check("ldi wr", bus.writeRegister, 3'd3);
        check("ldi regWrite", bus.regWrite, 1'b1);
        check("ldi immediate", bus.immediate, 1'b1);
        check("ldi ltValue", bus.ltValue, 8'h04);
        check("ldi aluOp", bus.aluOp, 3'b100);
        step();

        // backpressure: ADD held while SUB waits
        bus.outReady = 1'b0; bus.inValid = 1'b1; bus.instruction = 9'b000_001_010;
        step();
        bus.instruction = 9'b001_100_101;
        for (int i = 0; i < 3; i++) begin
            check("bp inReady", bus.inReady, 1'b0);
            check("bp rr1", bus.readRegister1, 3'd1);
            check("bp rr2", bus.readRegister2, 3'd2);
            step();
        end
        bus.outReady = 1'b1;
        #1 check("bp release inReady", bus.inReady, 1'b1);
        step();
        check("bp sub rr1", bus.readRegister1, 3'd4);
        check("bp sub rr2", bus.readRegister2, 3'd5);
        check("bp sub aluOp", bus.aluOp, 3'd1);
        bus.inValid = 1'b0;
        step();

        // load-use: LOAD r2,(r1) then ADD r2,r3
        b0 = mBubbles;
        bus.inValid = 1'b1; bus.instruction = 9'b101_010_001;
        step();
        bus.instruction = 9'b000_010_011;
        #1;
`ifdef DECODE_HAZARD_EN
        check("lu inReady", bus.inReady, 1'b0);
        step();
        check("lu bubble outValid", bus.outValid, 1'b0);
        check("lu bubbleCount", bus.bubbleCount, 8'(b0 + 1));
        step();
`else
        check("lu inReady", bus.inReady, 1'b1);
        step();
        check("lu bubbleCount", bus.bubbleCount, 8'd0);
`endif
        check("lu add outValid", bus.outValid, 1'b1);
        check("lu add rr1", bus.readRegister1, 3'd2);
        check("lu add rr2", bus.readRegister2, 3'd3);
        bus.inValid = 1'b0;
        step();

        // flush while LOAD held and dependent ADD pending
        bus.inValid = 1'b1; bus.instruction = 9'b101_010_001;
        step();
        b0 = mBubbles;
        bus.instruction = 9'b000_010_011; bus.flush = 1'b1;
        #1 check("flush inReady", bus.inReady, 1'b0);
        step();
        check("flush outValid", bus.outValid, 1'b0);
        check("flush bubbleCount", bus.bubbleCount, 8'(b0));
        bus.flush = 1'b0; bus.inValid = 1'b0;
        step();

        // asynchronous reset with an instruction held
        bus.inValid = 1'b1; bus.instruction = 9'b100_011_010; bus.outReady = 1'b0;
        step();
        bus.inValid = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check("async reset outValid", bus.outValid, 1'b0);
        check("async reset ltValue", bus.ltValue, 8'd0);
        check("async reset rr1", bus.readRegister1, 3'd0);
        step();
        resetN = 1'b1;
        #1 check("inReady after reset 2", bus.inReady, 1'b1);

        // saturation: self-dependent LOAD r2,(r2) alternates accept/bubble
        bus.outReady = 1'b1; bus.inValid = 1'b1; bus.instruction = 9'b101_010_010;
        repeat (540) step();
`ifdef DECODE_HAZARD_EN
        check("saturated bubbleCount", bus.bubbleCount, 8'd255);
`else
        check("disabled bubbleCount", bus.bubbleCount, 8'd0);
`endif
        bus.inValid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
